// File: rtl/block_xfer_pkg.sv
// rtl/block_xfer_pkg.sv - shared types and constants for the block-transfer engine
package block_xfer_pkg;

    typedef enum logic [2:0] {
        TII = 3'd0,
        TDD = 3'd1,
        TIN = 3'd2,
        TIA = 3'd3,
        TAI = 3'd4
    } xfer_mode_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        LAT  = 2'd2,
        WR   = 2'd3
    } xfer_state_t;

    typedef enum logic [1:0] {
        STEP_INC  = 2'd0,
        STEP_DEC  = 2'd1,
        STEP_HOLD = 2'd2,
        STEP_ALT  = 2'd3
    } ptr_step_t;

    localparam logic [2:0] MODE_MAX = 3'd4;

    function automatic ptr_step_t src_step(input xfer_mode_t m);
        case (m)
            TDD:     return STEP_DEC;
            TAI:     return STEP_ALT;
            default: return STEP_INC;
        endcase
    endfunction

    function automatic ptr_step_t dst_step(input xfer_mode_t m);
        case (m)
            TDD:     return STEP_DEC;
            TIN:     return STEP_HOLD;
            TIA:     return STEP_ALT;
            default: return STEP_INC;
        endcase
    endfunction

endpackage

// File: rtl/xfer_ptr.sv
// rtl/xfer_ptr.sv - one transfer address pointer (base, current, alternate toggle)
module xfer_ptr
    import block_xfer_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_base,
    input  logic              i_step,
    input  ptr_step_t         i_step_mode,
    output logic [ADDR_W-1:0] o_addr
);

    localparam logic [ADDR_W-1:0] ONE = 1;

    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] r_cur;
    logic              r_tog;
    logic [ADDR_W-1:0] w_next;
    logic              w_tog_next;

    // Alternate mode bounces between base and base+1, tracked by r_tog
    always_comb begin
        w_next     = r_cur;
        w_tog_next = r_tog;
        case (i_step_mode)
            STEP_INC: w_next = r_cur + ONE;
            STEP_DEC: w_next = r_cur - ONE;
            STEP_ALT: begin
                w_tog_next = ~r_tog;
                w_next     = r_tog ? r_base : r_base + ONE;
            end
            default: w_next = r_cur;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_base <= '0;
            r_cur  <= '0;
            r_tog  <= 1'b0;
        end else if (i_load) begin
            r_base <= i_base;
            r_cur  <= i_base;
            r_tog  <= 1'b0;
        end else if (i_step) begin
            r_cur  <= w_next;
            r_tog  <= w_tog_next;
        end
    end

    // While stepping, expose the stepped address so the caller can register it this edge
    assign o_addr = i_step ? w_next : r_cur;

endmodule

// File: rtl/block_xfer.sv
// rtl/block_xfer.sv - block-transfer bus initiator, read/latch/write per byte
module block_xfer
    import block_xfer_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [2:0]        i_mode,
    input  logic [ADDR_W-1:0] i_src,
    input  logic [ADDR_W-1:0] i_dst,
    input  logic [LEN_W-1:0]  i_len,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic              o_mem_we,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_busy,
    output logic              o_done
);

    localparam logic [LEN_W:0] REM_ONE  = 1;
    localparam logic [LEN_W:0] REM_FULL = {1'b1, {LEN_W{1'b0}}};

    xfer_state_t       r_state;
    xfer_state_t       w_state_nxt;
    xfer_mode_t        r_mode;
    logic [LEN_W:0]    r_remain;
    logic [LEN_W:0]    w_remain_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] w_wdata_nxt;
    logic              r_we;
    logic              w_we_nxt;
    logic              r_busy;
    logic              w_busy_nxt;
    logic              r_done;
    logic              w_done_nxt;

    logic              w_accept;
    logic              w_last;
    logic              w_step;
    logic [ADDR_W-1:0] w_src_addr;
    logic [ADDR_W-1:0] w_dst_addr;

    assign w_accept = (r_state == IDLE) && i_start && (i_mode <= MODE_MAX);
    assign w_last   = (r_remain == REM_ONE);
    assign w_step   = (r_state == WR);

    xfer_ptr #(.ADDR_W(ADDR_W)) u_src_ptr (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_load      (w_accept),
        .i_base      (i_src),
        .i_step      (w_step),
        .i_step_mode (src_step(r_mode)),
        .o_addr      (w_src_addr)
    );

    xfer_ptr #(.ADDR_W(ADDR_W)) u_dst_ptr (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_load      (w_accept),
        .i_base      (i_dst),
        .i_step      (w_step),
        .i_step_mode (dst_step(r_mode)),
        .o_addr      (w_dst_addr)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = RD;
            RD:      w_state_nxt = LAT;
            LAT:     w_state_nxt = WR;
            WR:      w_state_nxt = w_last ? IDLE : RD;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_addr_nxt   = r_addr;
        w_wdata_nxt  = r_wdata;
        w_we_nxt     = 1'b0;
        w_busy_nxt   = r_busy;
        w_done_nxt   = 1'b0;
        w_remain_nxt = r_remain;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_addr_nxt   = i_src;
                    w_busy_nxt   = 1'b1;
                    w_remain_nxt = (i_len == '0) ? REM_FULL : {1'b0, i_len};
                end
            end
            LAT: begin
                w_wdata_nxt = i_mem_rdata;
                w_addr_nxt  = w_dst_addr;
                w_we_nxt    = 1'b1;
            end
            WR: begin
                w_remain_nxt = r_remain - REM_ONE;
                if (w_last) begin
                    w_busy_nxt = 1'b0;
                    w_done_nxt = 1'b1;
                end else begin
                    w_addr_nxt = w_src_addr;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mode   <= TII;
            r_remain <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_we     <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_mode <= xfer_mode_t'(i_mode);
            end
            r_remain <= w_remain_nxt;
            r_addr   <= w_addr_nxt;
            r_wdata  <= w_wdata_nxt;
            r_we     <= w_we_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
        end
    end

    assign o_mem_addr  = r_addr;
    assign o_mem_wdata = r_wdata;
    assign o_mem_we    = r_we;
    assign o_busy      = r_busy;
    assign o_done      = r_done;

endmodule

// File: tb/tb_block_xfer.sv
// tb/tb_block_xfer.sv - self-checking bench for block_xfer against a per-byte transfer model
module tb_block_xfer;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;
    localparam int LEN_W  = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [2:0]        mode = '0;
    logic [ADDR_W-1:0] src = '0;
    logic [ADDR_W-1:0] dst = '0;
    logic [LEN_W-1:0]  len = '0;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_we;
    logic              busy;
    logic              done;
    logic              mem_init = 1'b1;

    logic [7:0] mem     [0:65535];
    logic [7:0] ref_mem [0:65535];
    logic [15:0] exp_a[$];
    logic [7:0]  exp_d[$];

    int n_checks = 0;
    int n_errors = 0;

    block_xfer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .i_mode      (mode),
        .i_src       (src),
        .i_dst       (dst),
        .i_len       (len),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .o_mem_we    (mem_we),
        .i_mem_rdata (mem_rdata),
        .o_busy      (busy),
        .o_done      (done)
    );

    always #5 clk = ~clk;

    // Synchronous memory responder: dOut holds the byte at last cycle's address
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 65536; i++) mem[i] <= 8'(i);
        end else if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
        mem_rdata <= mem[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic mem_image_check(input string tag);
        int nmis = 0;
        for (int i = 0; i < 65536; i++) if (mem[i] !== ref_mem[i]) nmis++;
        check(tag, nmis, 0);
    endtask

    // Byte k reads src+f(k) and writes dst+g(k), in order, on the model memory
    task automatic build_model(input int m, input int s, input int d, input int n);
        logic [15:0] sa, da;
        exp_a.delete();
        exp_d.delete();
        for (int k = 0; k < n; k++) begin
            case (m)
                0:       begin sa = 16'(s + k);       da = 16'(d + k);       end
                1:       begin sa = 16'(s - k);       da = 16'(d - k);       end
                2:       begin sa = 16'(s + k);       da = 16'(d);           end
                3:       begin sa = 16'(s + k);       da = 16'(d + (k & 1)); end
                default: begin sa = 16'(s + (k & 1)); da = 16'(d + k);       end
            endcase
            exp_a.push_back(da);
            exp_d.push_back(ref_mem[sa]);
            ref_mem[da] = ref_mem[sa];
        end
    endtask

    task automatic run_xfer(input int m, input int s, input int d, input int l,
                            input int poke_t, input string tag);
        int L = (l == 0) ? (1 << LEN_W) : l;
        int t = 0;
        int t_done = -1;
        int n_we = 0;
        int n_busy = 0;
        int bad_phase = 0;
        build_model(m, s, d, L);
        @(negedge clk);
        start = 1'b1;
        mode  = 3'(m);
        src   = 16'(s);
        dst   = 16'(d);
        len   = LEN_W'(l);
        @(posedge clk);
        while (t_done < 0 && t <= 3 * L + 6) begin
            @(negedge clk);
            start = 1'b0;
            if (t == poke_t) begin
                start = 1'b1;
                mode  = 3'($urandom_range(0, 4));
                src   = 16'($urandom);
                dst   = 16'($urandom);
                len   = LEN_W'($urandom);
            end
            if (busy) n_busy++;
            if (mem_we) begin
                n_we++;
                if (t % 3 != 2) bad_phase++;
                if (exp_a.size() > 0) begin
                    check({tag, "_waddr"}, mem_addr, exp_a.pop_front());
                    check({tag, "_wdata"}, mem_wdata, exp_d.pop_front());
                end else begin
                    check({tag, "_extra_we"}, 1, 0);
                end
            end
            if (done) t_done = t;
            t++;
        end
        start = 1'b0;
        check({tag, "_done_cycle"}, t_done, 3 * L);
        check({tag, "_we_pulses"}, n_we, L);
        check({tag, "_busy_cycles"}, n_busy, 3 * L);
        check({tag, "_we_phase"}, bad_phase, 0);
        @(negedge clk);
        check({tag, "_done_pulse"}, {busy, done}, 2'b00);
        mem_image_check({tag, "_mem"});
    endtask

    initial begin
        int nb;
        int nw;
        int nd;
        for (int i = 0; i < 65536; i++) ref_mem[i] = 8'(i);
        repeat (3) @(negedge clk);
        mem_init = 1'b0;
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_ctl", {mem_we, busy, done}, 3'b000);
        rst = 1'b0;
        @(negedge clk);

        run_xfer(0, 16'h1000, 16'h2000, 4, 4, "tii");
        for (int i = 0; i < 4; i++) check("tii_val", mem[16'h2000 + i], i);

        run_xfer(1, 16'h0003, 16'h8001, 5, -1, "tdd");
        check("tdd_8001", mem[16'h8001], 8'h03);
        check("tdd_7fff", mem[16'h7FFF], 8'h01);
        check("tdd_7ffd", mem[16'h7FFD], 8'hFF);

        run_xfer(3, 16'h0040, 16'h3000, 4, 7, "tia");
        check("tia_3000", mem[16'h3000], 8'h42);
        check("tia_3001", mem[16'h3001], 8'h43);

        run_xfer(4, 16'h0050, 16'h4000, 4, -1, "tai");
        check("tai_4002", mem[16'h4002], 8'h50);
        check("tai_4003", mem[16'h4003], 8'h51);

        run_xfer(2, 16'h0100, 16'h6000, 0, 37, "tin0");
        check("tin0_6000", mem[16'h6000], 8'hFF);

        // Reserved mode must not start anything
        @(negedge clk);
        start = 1'b1; mode = 3'd6; src = 16'h0020; dst = 16'h7100; len = 8'd3;
        nb = 0; nw = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy) nb++;
            if (mem_we) nw++;
        end
        check("mode6_busy", nb, 0);
        check("mode6_we", nw, 0);
        mem_image_check("mode6_mem");

        // Reset at E0+5 of a TII transfer: only byte 0 lands
        ref_mem[16'h5000] = ref_mem[16'h1234];
        @(negedge clk);
        start = 1'b1; mode = 3'd0; src = 16'h1234; dst = 16'h5000; len = 8'd8;
        @(posedge clk);
        nw = 0;
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            start = 1'b0;
            if (mem_we) nw++;
            if (t == 4) rst = 1'b1;
        end
        @(negedge clk);
        rst = 1'b0;
        check("midrst_we_before", nw, 1);
        check("midrst_ctl", {mem_we, busy, done}, 3'b000);
        check("midrst_addr", mem_addr, 0);
        check("midrst_wdata", mem_wdata, 0);
        nw = 0; nd = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (mem_we) nw++;
            if (done) nd++;
        end
        check("midrst_we_after", nw, 0);
        check("midrst_no_done", nd, 0);
        mem_image_check("midrst_mem");

        // Reset and start together: reset wins
        @(negedge clk);
        rst = 1'b1; start = 1'b1; mode = 3'd0; src = 16'h0010; dst = 16'h7000; len = 8'd2;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        nb = 0; nw = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (busy) nb++;
            if (mem_we) nw++;
        end
        check("rststart_busy", nb, 0);
        check("rststart_we", nw, 0);

        for (int r = 0; r < 20; r++) begin
            int rl;
            int rp;
            rl = $urandom_range(0, 10);
            rp = (rl >= 1) ? $urandom_range(0, 3 * rl - 2) : $urandom_range(0, 700);
            if (($urandom & 1) == 0) rp = -1;
            run_xfer($urandom_range(0, 4), $urandom_range(0, 65535),
                     $urandom_range(0, 65535), rl, rp, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
